qbus_ram: RTL



---
 rtl/qbus_ram.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/qbus_ram.sv
// qbus_ram: QBUS slave RAM occupying a 2^(AW+1)-byte window at BASE.
// Define QBUS_RAM_BYTE_EN to honour DATOB byte writes; otherwise every write is a full word.
module qbus_ram #(
    parameter logic [15:0] BASE     = 16'h0000,
    parameter int          AW       = 12,
    parameter int          RPLY_DLY = 1
) (
    input  logic        pin_clk,
    input  logic        pin_rst_n,
    input  logic        pin_init_n,
    inout  wire  [15:0] pin_ad_n,
    input  logic        pin_sync_n,
    input  logic        pin_din_n,
    input  logic        pin_dout_n,
    input  logic        pin_wtbt_n,
    output logic        pin_rply_n
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        SKIP  = 3'd2,
        RD    = 3'd3,
        RRPLY = 3'd4,
        WR    = 3'd5,
        WRPLY = 3'd6
    } state_t;

    localparam logic [16:0] WIN_SIZE = 17'd1 << (AW + 1);
    localparam logic [3:0]  DLY_LOAD = 4'(RPLY_DLY);

`ifdef QBUS_RAM_BYTE_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    // Registered copies of every bus input; all decisions below use these.
    logic        init_q;
    logic        sync_q;
    logic        din_q;
    logic        dout_q;
    logic        wtbt_q;
    logic [15:0] ad_q;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rply_q, rply_d;
    logic        oe_q, oe_d;
    logic        we;

    logic [15:0] mem [0:(2**AW)-1];
    logic [15:0] rdata_q;
    logic [AW-1:0] idx;
    logic [1:0]  be;
    logic [16:0] offset;
    logic        in_win;
    logic        unused_addr;

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            init_q <= 1'b1;
            sync_q <= 1'b1;
            din_q  <= 1'b1;
            dout_q <= 1'b1;
            wtbt_q <= 1'b1;
            ad_q   <= 16'hFFFF;
        end else begin
            init_q <= pin_init_n;
            sync_q <= pin_sync_n;
            din_q  <= pin_din_n;
            dout_q <= pin_dout_n;
            wtbt_q <= pin_wtbt_n;
            ad_q   <= pin_ad_n;
        end
    end

    // Offset is computed 17 bits wide so addresses below BASE wrap to a huge value.
    assign offset = {1'b0, ~ad_q} - {1'b0, BASE};
    assign in_win = (offset < WIN_SIZE);

    // Handshake: the master holds DIN/DOUT low until it sees RPLY; the slave holds
    // RPLY low until the strobe is seen released, then drops back to SEL.
    // SYNC released in any active state aborts the whole cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rply_d  = rply_q;
        oe_d    = oe_q;
        we      = 1'b0;
        if (state_q != IDLE && sync_q) begin
            state_d = IDLE;
            rply_d  = 1'b1;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!sync_q) begin
                        addr_d  = ~ad_q;
                        state_d = in_win ? SEL : SKIP;
                    end
                end
                SEL: begin
                    if (!din_q) begin
                        state_d = RD;
                        cnt_d   = DLY_LOAD;
                    end else if (!dout_q) begin
                        state_d = WR;
                        cnt_d   = DLY_LOAD;
                        we      = 1'b1;
                    end
                end
                SKIP: begin
                    state_d = SKIP;
                end
                RD: begin
                    if (cnt_q <= 4'd1) begin
                        rply_d  = 1'b0;
                        oe_d    = 1'b1;
                        state_d = RRPLY;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                RRPLY: begin
                    if (din_q) begin
                        rply_d  = 1'b1;
                        oe_d    = 1'b0;
                        state_d = SEL;
                    end
                end
                WR: begin
                    if (cnt_q <= 4'd1) begin
                        rply_d  = 1'b0;
                        state_d = WRPLY;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                WRPLY: begin
                    if (dout_q) begin
                        rply_d  = 1'b1;
                        state_d = SEL;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rply_d  = 1'b1;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            cnt_q   <= 4'd0;
            rply_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else if (!init_q) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            cnt_q   <= 4'd0;
            rply_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rply_q  <= rply_d;
            oe_q    <= oe_d;
        end
    end

    assign idx = addr_q[AW:1];
    assign unused_addr = ^addr_q;

    // Byte lane follows the odd/even address; the data byte comes from the same lane.
    always_comb begin
        be = 2'b11;
        if (BYTE_EN && !wtbt_q) begin
            be = addr_q[0] ? 2'b10 : 2'b01;
        end
    end

    // The write lands on the edge that enters WR, so an abort or INIT that follows
    // can only ever have touched the addressed word. Contents survive reset.
    always_ff @(posedge pin_clk) begin
        if (we && init_q) begin
            if (be[0]) mem[idx][7:0]  <= ~ad_q[7:0];
            if (be[1]) mem[idx][15:8] <= ~ad_q[15:8];
        end
        rdata_q <= mem[idx];
    end

    assign pin_rply_n = rply_q;
    assign pin_ad_n   = oe_q ? ~rdata_q : 16'hzzzz;

endmodule
